// File: rtl/divider_restoring_seq.sv
// divider_restoring_seq
// Multi-cycle unsigned restoring divider. Each RUN cycle does one
// shift-and-subtract step. A start/busy/done handshake connects it to the
// ALU control. A zero divisor skips the iterations and flags div_by_zero.

module divider_restoring_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers. a_reg shifts dividend bits out at the top and
  // quotient bits in at the bottom. d_reg holds the divisor for the whole run.
  // The partial remainder is conceptually WIDTH+1 bits. After every step it is
  // strictly less than the divisor, so its top bit is always zero and only
  // WIDTH bits are stored.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    step_cnt;

  logic             accept;
  logic             zero_div;
  logic             last_step;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] a_step;

  assign accept    = (state == IDLE) && start;
  assign zero_div  = (divisor == '0);
  assign last_step = (state == RUN) && (step_cnt == CW'(1));

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  always_comb begin
    r_shift = {r_reg, a_reg[WIDTH-1]};
    trial   = r_shift - {1'b0, d_reg};
    a_step  = {a_reg[WIDTH-2:0], ~trial[WIDTH]};
    if (!trial[WIDTH]) begin
      r_step = trial[WIDTH-1:0];
    end else begin
      r_step = r_shift[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the handshake outputs, which are decoded from the state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = zero_div ? FIN : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (step_cnt == CW'(1)) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Iteration datapath: load on a non-zero accept, then step once per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      d_reg    <= '0;
      r_reg    <= '0;
      step_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !zero_div) begin
            a_reg    <= dividend;
            d_reg    <= divisor;
            r_reg    <= '0;
            step_cnt <= CW'(WIDTH);
          end
        end
        RUN: begin
          a_reg    <= a_step;
          r_reg    <= r_step;
          step_cnt <= step_cnt - CW'(1);
        end
        default: begin
          a_reg    <= a_reg;
          d_reg    <= d_reg;
          r_reg    <= r_reg;
          step_cnt <= step_cnt;
        end
      endcase
    end
  end

  // Result registers. They update only on the edge into FIN and then hold until
  // the next division finishes. The final step's value is captured directly, so
  // the results are already valid during the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && zero_div) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (last_step) begin
      quotient    <= a_step;
      remainder   <= r_step;
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_divider_restoring_seq.sv
// tb_divider_restoring_seq
// Self-checking bench for the restoring divider. It uses directed corner cases
// plus random operand pairs. Expected results come from plain integer / and %.

module tb_divider_restoring_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checkCount = 0;
  int passCount  = 0;

  divider_restoring_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Starts a division on a negedge with the DUT idle. Then waits a bounded
  // number of cycles for done. Optionally pulses start with other operands
  // at cycle injectAt. Returns with the bench sitting in the done cycle.
  task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                               input int injectAt, input logic [W-1:0] injD,
                               input logic [W-1:0] injS,
                               output int lat, output int busyCycles,
                               output bit gotDone);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(negedge clk);
    start      = 1'b0;
    dividend   = W'($urandom);
    divisor    = W'($urandom);
    lat        = 1;
    busyCycles = 0;
    gotDone    = 1'b0;
    while (lat <= 40) begin
      if (done) begin
        gotDone = 1'b1;
        break;
      end
      if (busy) busyCycles++;
      if (lat == injectAt) begin
        start    = 1'b1;
        dividend = injD;
        divisor  = injS;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  // Compares one finished division against the arithmetic reference.
  // Then steps into the following idle cycle to check that done lasted one
  // cycle and that the results were held.
  task automatic checkResult(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                             input int lat, input int busyCycles, input bit gotDone);
    logic [W-1:0] expQ;
    logic [W-1:0] expR;
    logic         expZ;
    logic [31:0]  recon;
    bit           invOk;
    if (dvs == 0) begin
      expQ = '1;
      expR = dvd;
      expZ = 1'b1;
    end else begin
      expQ = dvd / dvs;
      expR = dvd % dvs;
      expZ = 1'b0;
    end
    checkOutput("doneSeen", 32'(gotDone), 32'd1);
    checkOutput("latency", 32'(lat), expZ ? 32'd1 : 32'd17);
    checkOutput("busyCycles", 32'(busyCycles), expZ ? 32'd0 : 32'd16);
    checkOutput("quotient", 32'(quotient), 32'(expQ));
    checkOutput("remainder", 32'(remainder), 32'(expR));
    checkOutput("divByZero", 32'(div_by_zero), 32'(expZ));
    if (!expZ) begin
      recon = 32'(quotient) * 32'(dvs) + 32'(remainder);
      invOk = (recon == 32'(dvd)) && (remainder < dvs);
      checkOutput("invariant", 32'(invOk), 32'd1);
    end
    @(negedge clk);
    checkOutput("donePulse", 32'(done), 32'd0);
    checkOutput("quotientHeld", 32'(quotient), 32'(expQ));
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'(1);
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    int busyCycles;
    bit gotDone;
    int doneHits;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstQuotient", 32'(quotient), 32'd0);
    checkOutput("rstRemainder", 32'(remainder), 32'd0);
    checkOutput("rstDbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    applyStimulus(16'd100, 16'd7, 0, '0, '0, lat, busyCycles, gotDone);
    checkResult(16'd100, 16'd7, lat, busyCycles, gotDone);
    applyStimulus(16'hFFFF, 16'd1, 0, '0, '0, lat, busyCycles, gotDone);
    checkResult(16'hFFFF, 16'd1, lat, busyCycles, gotDone);
    applyStimulus(16'hFFFF, 16'hFFFF, 0, '0, '0, lat, busyCycles, gotDone);
    checkResult(16'hFFFF, 16'hFFFF, lat, busyCycles, gotDone);
    applyStimulus(16'd3, 16'd10, 0, '0, '0, lat, busyCycles, gotDone);
    checkResult(16'd3, 16'd10, lat, busyCycles, gotDone);
    applyStimulus(16'd5, 16'd0, 0, '0, '0, lat, busyCycles, gotDone);
    checkResult(16'd5, 16'd0, lat, busyCycles, gotDone);

    // A start pulsed mid-run must be ignored. The 9/2 then goes back-to-back.
    applyStimulus(16'd100, 16'd7, 5, 16'd9, 16'd2, lat, busyCycles, gotDone);
    checkResult(16'd100, 16'd7, lat, busyCycles, gotDone);
    applyStimulus(16'd9, 16'd2, 0, '0, '0, lat, busyCycles, gotDone);
    checkResult(16'd9, 16'd2, lat, busyCycles, gotDone);

    // Reset at cycle 8 of a run clears the outputs and suppresses done.
    start    = 1'b1;
    dividend = 16'd1234;
    divisor  = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstQuotient", 32'(quotient), 32'd0);
    checkOutput("midRstRemainder", 32'(remainder), 32'd0);
    checkOutput("midRstDbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    doneHits = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) doneHits++;
    end
    checkOutput("noDoneAfterReset", 32'(doneHits), 32'd0);
    applyStimulus(16'd50, 16'd5, 0, '0, '0, lat, busyCycles, gotDone);
    checkResult(16'd50, 16'd5, lat, busyCycles, gotDone);

    // Random operand pairs, biased toward zero, one and the maximum value.
    for (int i = 0; i < 2000; i++) begin
      a = pickOperand();
      b = pickOperand();
      applyStimulus(a, b, 0, '0, '0, lat, busyCycles, gotDone);
      checkResult(a, b, lat, busyCycles, gotDone);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
